// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit scheduler.
//   sample_t   : one signed channel sample
//   state_t    : scheduler state (IDLE, RUN, DRAIN)
//   FRAME_BITS : BCK periods in one stereo frame (left + right slot)
package i2s_pkg;

  localparam int SAMPLE_BITS = 16;
  localparam int FRAME_BITS  = 2 * SAMPLE_BITS;

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/i2s_bck_gen.sv
// I2S bit-clock generator.
// Divides clk down to BCK. The half-period is div_cur+1 clk cycles, and div_cur
// is refreshed from div_val only when BCK toggles, so a divider change never
// shortens the phase already in progress. While stopped, BCK is held low and
// div_cur tracks div_val so a restart begins with a full, current half-period.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   run        : 1 = generate BCK, 0 = hold BCK low and the counter at 0
//   div_val    : BCK half-period minus 1, in clk cycles
//   bck        : bit clock
//   bck_fall   : high in the clk whose edge takes BCK from 1 to 0
module i2s_bck_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div_val,
  output logic             bck,
  output logic             bck_fall
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_cur;
  logic             toggle;

  assign toggle   = run && (cnt == div_cur);
  assign bck_fall = toggle && bck;

  // NOTE: registers are written with <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation results.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      div_cur <= '0;
      bck     <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      div_cur <= div_val;
      bck     <= 1'b0;
    end else if (toggle) begin
      cnt     <= '0;
      div_cur <= div_val;
      bck     <= !bck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx_sched.sv
// I2S transmit scheduler for the headphone/amp DAC path.
// Serialises stereo frames MSB first, data and WS changing on BCK fall. Samples
// enter a 1-deep pending buffer over valid/ready; each frame boundary loads the
// shifter with zeros (mute), the pending pair, or a repeat of the last pair
// (underrun). Dropping enable finishes the current frame before going idle.
// Ports:
//   clk, reset           : system clock, synchronous active-high reset
//   enable               : 1 = run, 0 = stop after the current frame
//   div_val              : BCK half-period minus 1, in clk cycles
//   mute                 : load zeros at the next frame boundary
//   sample_l, sample_r   : signed sample pair offered upstream
//   sample_valid/ready   : handshake into the pending buffer
//   hp_bck, hp_ws, hp_din: I2S bit clock, word select (0 = left), serial data
//   frame_strobe         : 1-clk pulse after each frame load
//   underrun             : 1-clk pulse when a frame was loaded with no pending pair
//   busy                 : scheduler not idle
module i2s_tx_sched
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = FRAME_BITS / 2,
  parameter int DIV_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           div_val,
  input  logic                       mute,
  input  logic signed [SAMPLE_W-1:0] sample_l,
  input  logic signed [SAMPLE_W-1:0] sample_r,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       hp_bck,
  output logic                       hp_ws,
  output logic                       hp_din,
  output logic                       frame_strobe,
  output logic                       underrun,
  output logic                       busy
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WS_HI_FROM = CNT_W'(SAMPLE_W - 1);

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_nxt;
  logic [FRAME_W-1:0] shift;
  logic [FRAME_W-1:0] pend;
  logic [FRAME_W-1:0] last;
  logic [FRAME_W-1:0] load_word;
  logic               pend_full;
  logic               bck_fall;
  logic               boundary;
  logic               start;
  logic               stop_now;
  logic               load_now;
  logic               accept;

  assign busy = (state != IDLE);

  i2s_bck_gen #(.DIV_W(DIV_W)) u_bck_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (busy),
    .div_val  (div_val),
    .bck      (hp_bck),
    .bck_fall (bck_fall)
  );

  // Frame length is a power of two, so the increment wraps 31 -> 0 by itself.
  assign bit_nxt  = bit_cnt + 1'b1;
  assign boundary = bck_fall && (bit_cnt == LAST_BIT);
  assign start    = !reset && (state == IDLE) && enable;
  assign stop_now = boundary && (state == DRAIN) && !enable;
  assign load_now = start || (!reset && boundary && !stop_now);

  // Ready also when the buffer is being emptied this very clk, so a held
  // valid is taken at the boundary without a bubble.
  assign sample_ready = !pend_full || load_now;
  assign accept       = sample_valid && sample_ready;

  always_comb begin
    // NOTE: default assigned first so every path drives load_word (no latch).
    load_word = last;
    if (mute) begin
      load_word = '0;
    end else if (pend_full) begin
      load_word = pend;
    end
  end

  assign hp_din = shift[FRAME_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      pend         <= '0;
      last         <= '0;
      pend_full    <= 1'b0;
      hp_ws        <= 1'b0;
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_strobe <= load_now;
      underrun     <= load_now && !mute && !pend_full;

      // A load and an accept in the same clk: the old pair goes out, the new
      // pair takes its place, so the buffer stays full.
      if (accept) begin
        pend      <= {sample_l, sample_r};
        pend_full <= 1'b1;
      end else if (load_now) begin
        pend_full <= 1'b0;
      end
      if (load_now && !mute && pend_full) begin
        last <= pend;
      end

      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable) begin
            state <= RUN;
          end else if (stop_now) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // WS for bit n is bit log2(SAMPLE_W) of n+1, i.e. high for bits
      // SAMPLE_W-1 .. FRAME_W-2; that makes WS lead each MSB by one bit.
      if (load_now) begin
        shift   <= load_word;
        bit_cnt <= '0;
        hp_ws   <= 1'b0;
      end else if (stop_now) begin
        shift   <= '0;
        bit_cnt <= '0;
        hp_ws   <= 1'b0;
      end else if (bck_fall) begin
        shift   <= {shift[FRAME_W-2:0], 1'b0};
        bit_cnt <= bit_nxt;
        hp_ws   <= (bit_nxt >= WS_HI_FROM) && (bit_nxt != LAST_BIT);
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Testbench for i2s_tx_sched: a table of frames (push, mute, expected word,
// expected underrun) followed by hand-written sequences for the handshake at a
// boundary, drain/re-enable, divider change and reset mid-frame.
module tb_i2s_tx_sched;
  import i2s_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       mute = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] div_val = 8'd3;
  sample_t    sample_l = '0;
  sample_t    sample_r = '0;
  logic       sample_ready, hp_bck, hp_ws, hp_din, frame_strobe, underrun, busy;

  always #5 clk = ~clk;

  i2s_tx_sched #(.SAMPLE_W(16), .DIV_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .div_val      (div_val),
    .mute         (mute),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .hp_bck       (hp_bck),
    .hp_ws        (hp_ws),
    .hp_din       (hp_din),
    .frame_strobe (frame_strobe),
    .underrun     (underrun),
    .busy         (busy)
  );

  localparam logic [31:0] WS_WORD = 32'h0001_FFFE;  // WS per bit, bit 0 at [31]

  typedef struct {
    bit          push;
    bit          mute;
    sample_t     l;
    sample_t     r;
    logic [31:0] exp_data;
    bit          exp_uf;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] ws;
  } word_t;

  vec_t  vt[10];
  word_t rx_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    mon_idx = 0;
  int    mon_strobes = 0;

  // Receiver: captures din/ws on each BCK rise, frames re-aligned by frame_strobe.
  initial begin
    logic [31:0] sr_d, sr_w;
    logic        prev_bck;
    sr_d = '0; sr_w = '0; prev_bck = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_idx  = 0;
        prev_bck = 1'b0;
      end else begin
        if (frame_strobe) begin
          mon_idx = 0;
          mon_strobes++;
        end
        if (hp_bck && !prev_bck) begin
          sr_d = {sr_d[30:0], hp_din};
          sr_w = {sr_w[30:0], hp_ws};
          mon_idx++;
          if (mon_idx == 32) begin
            rx_q.push_back('{sr_d, sr_w});
            mon_idx = 0;
          end
        end
        prev_bck = hp_bck;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_strobe(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      step();
      got = frame_strobe;
    end
    if (!got) check({name, " timeout"}, 32'(got), 32'd1);
  endtask

  task automatic wait_idx(input int n, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      step();
      got = (mon_idx == n);
    end
    if (!got) check({name, " timeout"}, 32'(got), 32'd1);
  endtask

  task automatic wait_toggle(output int n);
    logic prev = hp_bck;
    n = -1;
    for (int i = 1; i <= 600 && n < 0; i++) begin
      step();
      if (hp_bck !== prev) n = i;
    end
    if (n < 0) check("bck toggle timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input sample_t l, input sample_t r, input string name);
    bit done = 1'b0;
    sample_l = l;
    sample_r = r;
    sample_valid = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      #1;
      done = sample_ready;
      step();
    end
    sample_valid = 1'b0;
    if (!done) check({name, " timeout"}, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " bck"},      32'(hp_bck),       32'd0);
    check({tag, " ws"},       32'(hp_ws),        32'd0);
    check({tag, " din"},      32'(hp_din),       32'd0);
    check({tag, " strobe"},   32'(frame_strobe), 32'd0);
    check({tag, " underrun"}, 32'(underrun),     32'd0);
    check({tag, " busy"},     32'(busy),         32'd0);
    check({tag, " ready"},    32'(sample_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, t0, t1, s0;
    bit saw_hi;
    vt[0] = '{1'b1, 1'b0, 16'h8001, 16'h7FFE, 32'h8001_7FFE, 1'b0};
    vt[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 32'h8001_7FFE, 1'b1};
    vt[2] = '{1'b1, 1'b0, 16'h1234, 16'h5678, 32'h1234_5678, 1'b0};
    vt[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 32'h1234_5678, 1'b1};
    vt[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 32'h1234_5678, 1'b1};
    vt[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 32'h1234_5678, 1'b1};
    vt[6] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0000, 1'b0};
    vt[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 32'h1234_5678, 1'b1};
    vt[8] = '{1'b1, 1'b0, 16'h0001, 16'h8000, 32'h0001_8000, 1'b0};
    vt[9] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0};

    // Reset state
    step(); step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();
    rx_q.delete();

    // Frame table at div_val=3: first pair is pending while still idle
    push(vt[0].l, vt[0].r, "push v0");
    check("idle while pending", 32'(busy), 32'd0);
    mute   = vt[0].mute;
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_strobe($sformatf("strobe v%0d", k));
      check($sformatf("v%0d underrun", k), 32'(underrun), 32'(vt[k].exp_uf));
      mute = (k < 9) ? vt[k+1].mute : 1'b0;
      if (k < 9 && vt[k+1].push) push(vt[k+1].l, vt[k+1].r, $sformatf("push v%0d", k + 1));
    end
    for (int i = 0; i < 600 && rx_q.size() < 10; i++) step();
    check("table word count", 32'(rx_q.size() >= 10), 32'd1);
    for (int k = 0; k < 10; k++) begin
      if (k < rx_q.size()) begin
        check($sformatf("v%0d data", k), rx_q[k].data, vt[k].exp_data);
        check($sformatf("v%0d ws", k), rx_q[k].ws, WS_WORD);
      end
    end

    // BCK period at div_val=3
    wait_toggle(n);
    wait_toggle(n);
    wait_toggle(n2);
    check("bck period", 32'(n + n2), 32'd8);

    // Held valid with pending full is taken exactly at the boundary
    wait_strobe("t3 sync");
    push(16'hA5A5, 16'h0F0F, "t3 push A");
    check("t3 ready low while full", 32'(sample_ready), 32'd0);
    push(16'h3C3C, 16'hC3C3, "t3 push B");
    check("t3 accept at load", 32'(frame_strobe), 32'd1);
    check("t3 A underrun", 32'(underrun), 32'd0);
    rx_q.delete();
    wait_strobe("t3 B load");
    check("t3 B underrun", 32'(underrun), 32'd0);
    wait_strobe("t3 repeat");
    check("t3 repeat underrun", 32'(underrun), 32'd1);
    check("t3 word count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() >= 2) begin
      check("t3 first A", rx_q[0].data, 32'hA5A5_0F0F);
      check("t3 then B", rx_q[1].data, 32'h3C3C_C3C3);
    end

    // Stop mid-frame: frame runs to bit 31, then idle with BCK low
    push(16'h1357, 16'h2468, "t5 push C");
    wait_strobe("t5 load C");
    rx_q.delete();
    s0 = mon_strobes;
    wait_idx(5, "t5 bit5");
    enable = 1'b0;
    for (int i = 0; i < 600 && busy; i++) step();
    check("t5 drained", 32'(busy), 32'd0);
    check("t5 bck low", 32'(hp_bck), 32'd0);
    check("t5 din low", 32'(hp_din), 32'd0);
    check("t5 no load at stop", 32'(mon_strobes), 32'(s0));
    check("t5 word count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() >= 1) check("t5 frame C", rx_q[0].data, 32'h1357_2468);
    saw_hi = 1'b0;
    repeat (20) begin
      step();
      if (hp_bck) saw_hi = 1'b1;
    end
    check("t5 bck idles low", 32'(saw_hi), 32'd0);

    // Re-enable from idle, then drop and restore enable mid-frame: no gap
    enable = 1'b1;
    wait_strobe("t5 restart");
    check("t5 restart underrun", 32'(underrun), 32'd1);
    t0 = cyc;
    wait_idx(5, "t5b bit5");
    enable = 1'b0;
    repeat (40) step();
    check("t5 busy in drain", 32'(busy), 32'd1);
    enable = 1'b1;
    wait_strobe("t5 next frame");
    t1 = cyc;
    check("t5 frame spacing", 32'(t1 - t0), 32'd256);

    // Divider change mid-phase, then reset mid-frame and restart
    wait_idx(10, "t6 bit10");
    push(16'h4444, 16'h5555, "t6 push D");
    wait_toggle(n);
    if (!hp_bck) wait_toggle(n);
    step();
    div_val = 8'd0;
    wait_toggle(n);
    check("t6 high phase keeps old div", 32'(n + 1), 32'd4);
    wait_toggle(n);
    check("t6 low phase uses new div", 32'(n), 32'd1);
    reset = 1'b1;
    step();
    check_reset_outputs("t6 reset");
    reset = 1'b0;
    wait_strobe("t6 restart");
    check("t6 pending cleared", 32'(underrun), 32'd1);
    check("t6 busy", 32'(busy), 32'd1);
    wait_toggle(n);
    check("t6 first half", 32'(n), 32'd1);
    wait_toggle(n);
    check("t6 second half", 32'(n), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
